// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the iterative multiplier.
//   mul_state_e  : controller state (IDLE, BUSY, DONE)
//   mul_latency  : accept-edge to out_valid distance, in clock edges, for a
//                  non-bypassed operation of width w
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic int mul_latency(input int w);
    return w;
  endfunction

endpackage

// File: rtl/mul_sign_unit.sv
// mul_sign_unit: combinational sign handling around the unsigned shift-add core.
//   a, b, is_signed -> mag_a, mag_b : operand magnitudes (abs only when signed)
//                      neg          : product must be negated
//   acc, acc_neg    -> product      : 2W-bit result, two's-complement negated
//                                     when acc_neg is set
// |-2^(W-1)| is 2^(W-1), which still fits the W-bit unsigned magnitude.
module mul_sign_unit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               acc_neg,
  output logic [2*WIDTH-1:0] product
);

  always_comb begin
    mag_a   = (is_signed && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
    mag_b   = (is_signed && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
    neg     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    product = acc_neg ? (~acc) + (2*WIDTH)'(1) : acc;
  end

endmodule

// File: rtl/iter_multiplier.sv
// iter_multiplier: sequential shift-add W x W -> 2W multiplier with
// valid/ready on both sides and a pass-through tag.
//   clk, reset (sync, active high)
//   in_valid/in_ready, in_a, in_b, in_signed, in_tag : request
//   out_valid/out_ready, out_product, out_tag         : response
// One multiplier bit is consumed per BUSY cycle, so a result appears W edges
// after the accept edge. A new request may be accepted on the same edge that
// retires the previous result.
// Optional feature: define MUL_ZERO_BYPASS_EN to send ops with a zero operand
// straight to DONE with product 0.
module iter_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int CW = $clog2(WIDTH);

  mul_state_e         state;
  logic [WIDTH-1:0]   mcand, mplier;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc, acc_next, prod_fin;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_d, accept, last, zero_op;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (count == CW'(WIDTH - 1));
  assign acc_next  = acc + (mplier[count] ? ({{WIDTH{1'b0}}, mcand} << count)
                                          : '0);

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (in_a == '0) | (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The negate side works on acc_next so the final add and the sign fix-up
  // land in out_product on the same edge.
  mul_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .a         (in_a),
    .b         (in_b),
    .is_signed (in_signed),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg       (neg_d),
    .acc       (acc_next),
    .acc_neg   (neg_q),
    .product   (prod_fin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_product <= '0;
      out_tag     <= '0;
      count       <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      neg_q       <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (last) begin
            out_product <= prod_fin;
            state       <= DONE;
          end
        end
        DONE:    if (out_ready && !in_valid) state <= IDLE;
        default: ;
      endcase
      // Accept overrides the DONE retire transition (no bubble).
      if (accept) begin
        mcand   <= mag_a;
        mplier  <= mag_b;
        neg_q   <= neg_d;
        out_tag <= in_tag;
        acc     <= '0;
        count   <= '0;
        if (zero_op) begin
          out_product <= '0;
          state       <= DONE;
        end else begin
          state <= BUSY;
        end
      end
    end
  end

endmodule
